// File: rtl/i_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch_pkg
//  Description : Shared constants, FSM state encoding and helpers for the
//                DLX instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package i_fetch_pkg;

  // DLX NOP (opcode 6'h15), used for squashed slots and bubbles
  localparam logic [31:0] c_nop_insn = 32'h5400_0000;
  // First fetch address after reset
  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Retired-instruction counter step: bubbles never count
  function automatic logic [31:0] count_step(input logic [31:0] cnt,
                                             input logic [31:0] insn,
                                             input logic [31:0] nop);
    count_step = cnt + {31'd0, (insn != nop)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i_fetch_adder_n.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch_adder_n
//  Description : Parameterised N-bit adder with carry-in; carry-out is not
//                needed by the fetch stage, so the sum wraps modulo 2^N.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_fetch_adder_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i + {{(WIDTH-1){1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/i_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch
//  Description : DLX instruction-fetch stage. Owns the PC, talks to a
//                variable-latency instruction memory and drives the IF/ID
//                register consumed by i_decode. Handles stalls, redirects
//                and wrong-path squashing.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] NOP_INSN = c_nop_insn
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_lock,
  input  logic        reg_lock_if,
  input  logic        jump_or_branch,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_four,
  output logic [31:0] fetch_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] count_q, count_d;
  logic [31:0] hold_q, hold_d;

  logic [31:0] pc_inc;
  logic        stall;
  logic        redirect;
  logic        consume;

  assign stall    = reg_lock | reg_lock_if;
  // Only a global hazard stall blocks a redirect; decode NOP insertion does not
  assign redirect = jump_or_branch & ~reg_lock;

  i_fetch_adder_n #(
    .WIDTH (32)
  ) u_pc_adder (
    .a_i   (pc_q),
    .b_i   (32'h0000_0004),
    .cin_i (1'b0),
    .sum_o (pc_inc)
  );

  // A response taken straight into IF/ID lets the next request go out in the
  // same cycle (address pc+4), giving one instruction per cycle back-to-back.
  // When the response is stalled or redirected, the request line drops so no
  // new request is accepted on that edge.
  assign consume   = (state_q == ST_REQ) & imem_valid & ~stall & ~redirect;
  assign imem_req  = (state_q == ST_REQ) & (~imem_valid | consume);
  assign imem_addr = consume ? pc_inc : pc_q;

  assign instruction  = insn_q;
  assign pc_plus_four = pc4_q;
  assign fetch_count  = count_q;

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      insn_q  <= NOP_INSN;
      pc4_q   <= 32'd0;
      count_q <= 32'd0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      pc4_q   <= pc4_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and IF/ID update; redirect outranks everything else
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    pc4_d   = pc4_q;
    count_d = count_q;
    hold_d  = hold_q;

    if (redirect) begin
      pc_d   = target;
      insn_d = NOP_INSN;
      hold_d = 32'd0;
      // A request still in flight must have its response discarded first
      if (((state_q == ST_REQ) || (state_q == ST_FLUSH)) && !imem_valid) begin
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      // Bubble by default when the pipe moves and nothing is delivered
      if (!stall) begin
        insn_d = NOP_INSN;
      end
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_valid) begin
            if (stall) begin
              hold_d  = imem_rdata;
              state_d = ST_HOLD;
            end else begin
              insn_d  = imem_rdata;
              pc4_d   = pc_inc;
              pc_d    = pc_inc;
              count_d = count_step(count_q, imem_rdata, NOP_INSN);
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            insn_d  = hold_q;
            pc4_d   = pc_inc;
            pc_d    = pc_inc;
            count_d = count_step(count_q, hold_q, NOP_INSN);
            hold_d  = 32'd0;
            state_d = ST_REQ;
          end
        end
        ST_FLUSH: begin
          // Late response belongs to the abandoned path: drop it
          if (imem_valid) begin
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i_fetch
//  Description : Directed self-checking bench for i_fetch with a simple
//                variable-latency instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_fetch;

  localparam logic [31:0] NOP = 32'h5400_0000;

  logic        clk;
  logic        rst_n;
  logic        reg_lock;
  logic        reg_lock_if;
  logic        jump_or_branch;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction;
  logic [31:0] pc_plus_four;
  logic [31:0] fetch_count;

  int n_chk = 0;
  int n_err = 0;

  // memory model state
  int          lat;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  i_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_lock       (reg_lock),
    .reg_lock_if    (reg_lock_if),
    .jump_or_branch (jump_or_branch),
    .target         (target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .instruction    (instruction),
    .pc_plus_four   (pc_plus_four),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at an address: distinct per address, never a NOP
  function automatic logic [31:0] word(input logic [31:0] a);
    word = 32'h1000_0000 | (a & 32'h0FFF_FFFF);
  endfunction

  // Memory: accepts a request when idle or on its own response cycle,
  // answers lat cycles later with a one-cycle valid pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= 32'd0;
    end else if (m_busy && m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end else if (imem_req) begin
      m_busy <= 1'b1;
      m_addr <= imem_addr;
      m_cnt  <= lat - 1;
    end else begin
      m_busy <= 1'b0;
    end
  end

  assign imem_valid = m_busy && (m_cnt == 0);
  assign imem_rdata = imem_valid ? word(m_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    reg_lock       = 1'b0;
    reg_lock_if    = 1'b0;
    jump_or_branch = 1'b0;
    target         = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    lat = 1;
    do_reset();
    // ---------------- reset values (taken while held in reset) ----------
    rst_n = 1'b0;
    #1;
    check("rst_insn", instruction, NOP);
    check("rst_pc4", pc_plus_four, 32'd0);
    check("rst_cnt", fetch_count, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);

    // ---------------- straight line, latency 1 ----------------
    do_reset();
    tick();                                       // IDLE -> REQ
    check("s1_req", {31'd0, imem_req}, 32'd1);
    check("s1_addr", imem_addr, 32'd0);
    tick();                                       // response for 0 present
    check("s1_bubble", instruction, NOP);
    tick();
    check("s1_i0", instruction, word(32'd0));
    check("s1_p0", pc_plus_four, 32'd4);
    tick();
    check("s1_i1", instruction, word(32'd4));
    check("s1_p1", pc_plus_four, 32'd8);
    tick();
    check("s1_i2", instruction, word(32'd8));
    check("s1_p2", pc_plus_four, 32'd12);
    check("s1_cnt", fetch_count, 32'd3);
    // decode NOP-insertion stall freezes IF/ID as word @12 returns
    reg_lock_if = 1'b1;
    #1;
    check("s1_lif_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("s1_lif_insn", instruction, word(32'd8));
    check("s1_lif_cnt", fetch_count, 32'd3);

    // ---------------- stall during response ----------------
    do_reset();
    tick(); tick(); tick(); tick();               // word @8 now returning
    check("s2_pre", instruction, word(32'd4));
    reg_lock = 1'b1;
    #1;
    check("s2_req_drop", {31'd0, imem_req}, 32'd0);
    tick();
    check("s2_hold_req", {31'd0, imem_req}, 32'd0);
    check("s2_hold_insn", instruction, word(32'd4));
    tick();
    tick();
    check("s2_frozen_insn", instruction, word(32'd4));
    check("s2_frozen_pc4", pc_plus_four, 32'd8);
    check("s2_frozen_cnt", fetch_count, 32'd2);
    reg_lock = 1'b0;
    tick();
    check("s2_rel_insn", instruction, word(32'd8));
    check("s2_rel_pc4", pc_plus_four, 32'd12);
    check("s2_rel_cnt", fetch_count, 32'd3);
    check("s2_rel_addr", imem_addr, 32'd12);
    check("s2_rel_req", {31'd0, imem_req}, 32'd1);

    // ---------------- redirect with outstanding request, latency 4 -------
    lat = 4;
    do_reset();
    tick(); tick();                               // request for 0 accepted
    jump_or_branch = 1'b1;
    target         = 32'h100;
    tick();                                       // -> FLUSH
    jump_or_branch = 1'b0;
    check("s3_squash", instruction, NOP);
    check("s3_flush_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (instruction != NOP) break;
      tick();
    end
    check("s3_first", instruction, word(32'h100));
    check("s3_pc4", pc_plus_four, 32'h104);
    check("s3_cnt", fetch_count, 32'd1);

    // ---------------- redirect same cycle as response ----------------
    lat = 1;
    do_reset();
    tick(); tick();                               // response for 0 present
    jump_or_branch = 1'b1;
    target         = 32'h100;
    #1;
    check("s4_req_drop", {31'd0, imem_req}, 32'd0);
    tick();
    jump_or_branch = 1'b0;
    check("s4_addr", imem_addr, 32'h100);
    check("s4_insn", instruction, NOP);
    check("s4_cnt", fetch_count, 32'd0);
    tick();
    check("s4_req", {31'd0, imem_req}, 32'd1);
    tick(); tick();
    check("s4_i", instruction, word(32'h100));
    check("s4_cnt2", fetch_count, 32'd1);

    // ---------------- redirect under reg_lock ignored ----------------
    do_reset();
    tick();                                       // REQ for 0
    reg_lock       = 1'b1;
    jump_or_branch = 1'b1;
    target         = 32'h200;
    tick();                                       // response for 0 present
    check("s5_pc_kept", imem_addr, 32'd0);
    tick();                                       // HOLD
    check("s5_hold_insn", instruction, NOP);
    reg_lock = 1'b0;
    tick();                                       // redirect accepted
    jump_or_branch = 1'b0;
    check("s5_addr", imem_addr, 32'h200);
    check("s5_insn", instruction, NOP);
    tick();
    check("s5_req", {31'd0, imem_req}, 32'd1);
    check("s5_req_addr", imem_addr, 32'h200);
    tick(); tick();
    check("s5_i", instruction, word(32'h200));
    check("s5_cnt", fetch_count, 32'd1);

    // ---------------- async reset mid-FLUSH ----------------
    do_reset();
    tick(); tick();
    lat = 4;
    tick();                                       // IF/ID = word0, req @4 accepted
    check("s6_pre_cnt", fetch_count, 32'd1);
    jump_or_branch = 1'b1;
    target         = 32'h300;
    tick();                                       // -> FLUSH
    jump_or_branch = 1'b0;
    check("s6_pre_pc4", pc_plus_four, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_ar_pc4", pc_plus_four, 32'd0);
    check("s6_ar_cnt", fetch_count, 32'd0);
    check("s6_ar_insn", instruction, NOP);
    lat = 1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check("s6_req", {31'd0, imem_req}, 32'd1);
    check("s6_addr", imem_addr, 32'd0);
    tick(); tick();
    check("s6_i", instruction, word(32'd0));

    // ---------------- PC wrap ----------------
    do_reset();
    tick();
    jump_or_branch = 1'b1;
    target         = 32'hFFFF_FFFC;
    tick();                                       // -> FLUSH
    jump_or_branch = 1'b0;
    tick();                                       // stale response dropped
    check("s7_addr", imem_addr, 32'hFFFF_FFFC);
    tick();                                       // response for FFFFFFFC
    check("s7_next_addr", imem_addr, 32'd0);
    check("s7_next_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("s7_i", instruction, word(32'hFFFF_FFFC));
    check("s7_pc4", pc_plus_four, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
